alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single 32-bit ALU datapath between two requesters, port 0 and port 1, for example two issue slots or a main pipe plus a debug/multi-cycle unit.
- Uses round-robin arbitration and a valid/ready handshake on each request port.
- Registers the operands into the ALU and captures the ALU result and zero flag into a held response register returned over a valid/ready response port.
- Sits between the decode/issue logic and the ALU instance; the ALU itself stays external and combinational.

Parameters:
- DATA_W, 32, operand/result width; must match the ALU src/result width.
- CTRL_W, 4, ALU control width.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- req0_valid_i  input  1  port 0 request valid.
- req0_ready_o  output  1  port 0 request accepted this cycle when high with valid.
- req0_src1_i  input  DATA_W  port 0 operand 1.
- req0_src2_i  input  DATA_W  port 0 operand 2.
- req0_ctrl_i  input  CTRL_W  port 0 ALU op.
- req1_valid_i, req1_ready_o, req1_src1_i, req1_src2_i, req1_ctrl_i: same as port 0, for port 1.
- alu_src1_o  output  DATA_W  registered operand 1 to ALU.
- alu_src2_o  output  DATA_W  registered operand 2 to ALU.
- alu_ctrl_o  output  CTRL_W  registered op to ALU.
- alu_result_i  input  DATA_W  ALU result.
- alu_zero_i  input  1  ALU zero flag.
- rsp_valid_o  output  1  response valid.
- rsp_ready_i  input  1  response consumer ready.
- rsp_id_o  output  1  requester index of the response.
- rsp_result_o  output  DATA_W  captured result.
- rsp_zero_o  output  1  captured zero flag.
- rsp_err_o  output  1  op code was unsupported.

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values:
  - All registered outputs are 0.
  - last_grant register resets to 1, so port 0 wins the first contention.
  - Both ready outputs are 0 while rst_i is low.
- Accept condition: accept_ok = (state==IDLE) || (state==RESP && rsp_ready_i).
- Grant selection:
  - If only one port is valid, that port is granted.
  - If both are valid, the port != last_grant is granted.
  - reqN_ready_o = accept_ok && grant==N. At most one ready is high per cycle.
- On acceptance (valid && ready):
  - Latch src1/src2/ctrl into the alu_*_o registers and latch rsp id.
  - last_grant <= granted port.
  - state <= EXEC.
- EXEC (exactly one cycle):
  - rsp_result_o <= alu_result_i, rsp_zero_o <= alu_zero_i, rsp_err_o <= 0, rsp_valid_o <= 1, state <= RESP.
- Supported op codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
  - On any other code, the EXEC capture instead forces rsp_result_o=0, rsp_zero_o=1, rsp_err_o=1.
- RESP:
  - Response fields are held stable while rsp_valid_o=1 && !rsp_ready_i.
  - On rsp_ready_i with no new acceptance: rsp_valid_o <= 0, state <= IDLE.
  - On rsp_ready_i with a new acceptance in the same cycle: rsp_valid_o <= 0, state <= EXEC (back-to-back).
- Latency and throughput:
  - Acceptance edge N; rsp_valid_o is high after edge N+1.
  - Sustained throughput is one op per 2 cycles with rsp_ready_i held high.
- alu_*_o hold their last value outside EXEC; no re-issue occurs.
- A requester not granted must see ready=0 and may hold or change its payload freely.
- Reset asserted mid-operation: the FSM returns to IDLE asynchronously, the pending response is discarded, and rsp_valid_o drops immediately.
- Ready is combinational from rsp_ready_i and the valids. No combinational path exists from alu_result_i to any output.

Optional Feature:
- ALU_ARB_PERF_EN.
- When defined, adds output ports perf_grant0_o [31:0], perf_grant1_o [31:0] and perf_stall_o [31:0]:
  - perf_grant0_o / perf_grant1_o increment on each acceptance from port 0 / port 1.
  - perf_stall_o increments each cycle with rsp_valid_o=1 && !rsp_ready_i.
  - All three reset to 0 and wrap modulo 2^32.
- When undefined, these ports and counters do not exist and the remaining behaviour is identical.

Test Plan:
- Reset then port0 valid with src1=5, src2=3, ctrl=0010, rsp_ready=1 -> req0_ready=1 on the first cycle; 1 cycle later rsp_valid=1, rsp_result=8, rsp_zero=0, rsp_id=0.
- Both ports valid continuously (p0 SUB 7-7, p1 OR 0xF0|0x0F), rsp_ready=1 -> grants alternate 0,1,0,1; results 0 (zero=1), 0xFF (zero=0); a response every 2 cycles.
- Response backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> result/id/zero held constant; both ready=0; port1 valid is accepted in the same cycle rsp_ready rises.
- SLT src1=2, src2=9 -> result 1; then ctrl=0011 -> rsp_err=1, result 0, zero=1, FSM returns to IDLE normally.
- Assert rst_i low during EXEC -> rsp_valid=0 immediately; after release, port0 wins the first contention.
- With ALU_ARB_PERF_EN: 3 port-0 ops, 2 port-1 ops, 4 backpressure cycles -> perf_grant0=3, perf_grant1=2, perf_stall=4.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
//
// Round-robin arbitration between request ports 0 and 1, each with its own
// valid/ready handshake. The winning operands are registered toward the ALU.
// One cycle later the ALU result and zero flag are captured into a response
// register. That register is held on a valid/ready response port until the
// consumer takes it.
//
// Ports:
//   clk_i, rst_i                       clock (rising edge), async active-low reset
//   reqN_valid_i / reqN_ready_o        request handshake, N = 0, 1
//   reqN_src1_i, reqN_src2_i, ctrl_i   request payload
//   alu_src1_o, alu_src2_o, alu_ctrl_o registered operands/op to the ALU
//   alu_result_i, alu_zero_i           ALU outputs (captured only, never passed through)
//   rsp_valid_o / rsp_ready_i          response handshake
//   rsp_id_o, rsp_result_o, rsp_zero_o, rsp_err_o  response payload
//
// Optional feature macro ALU_ARB_PERF_EN adds perf_grant0_o, perf_grant1_o
// and perf_stall_o. These are 32-bit wrapping event counters.
//
// state | meaning
// IDLE  | no operation in flight, ready to accept
// EXEC  | operands presented to ALU, result captured at end of cycle
// RESP  | response held until rsp_ready_i; may accept the next op the same cycle

module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [DATA_W-1:0] req0_src1_i,
    input  logic [DATA_W-1:0] req0_src2_i,
    input  logic [CTRL_W-1:0] req0_ctrl_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [DATA_W-1:0] req1_src1_i,
    input  logic [DATA_W-1:0] req1_src2_i,
    input  logic [CTRL_W-1:0] req1_ctrl_i,
    output logic [DATA_W-1:0] alu_src1_o,
    output logic [DATA_W-1:0] alu_src2_o,
    output logic [CTRL_W-1:0] alu_ctrl_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_zero_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_id_o,
    output logic [DATA_W-1:0] rsp_result_o,
    output logic              rsp_zero_o,
    output logic              rsp_err_o
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [31:0]       perf_grant0_o,
    output logic [31:0]       perf_grant1_o,
    output logic [31:0]       perf_stall_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q;
    logic              last_grant_q;
    logic [DATA_W-1:0] src1_q;
    logic [DATA_W-1:0] src2_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic              rsp_valid_q;
    logic              rsp_id_q;
    logic [DATA_W-1:0] rsp_result_q;
    logic              rsp_zero_q;
    logic              rsp_err_q;

    logic              accept_ok;
    logic              grant_d;
    logic              accept;
    logic              op_ok;

    assign accept_ok = (state_q == IDLE) || ((state_q == RESP) && rsp_ready_i);

    // Contention goes to the port that did not win last time.
    always_comb begin
        grant_d = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            grant_d = ~last_grant_q;
        end else if (req1_valid_i) begin
            grant_d = 1'b1;
        end
    end

    // Gated by rst_i so neither port sees ready while reset is held.
    assign req0_ready_o = rst_i && accept_ok && !grant_d;
    assign req1_ready_o = rst_i && accept_ok &&  grant_d;

    assign accept = (req0_valid_i && req0_ready_o) || (req1_valid_i && req1_ready_o);

    always_comb begin
        op_ok = 1'b0;
        if ((ctrl_q == CTRL_W'(4'b0000)) || (ctrl_q == CTRL_W'(4'b0001)) ||
            (ctrl_q == CTRL_W'(4'b0010)) || (ctrl_q == CTRL_W'(4'b0110)) ||
            (ctrl_q == CTRL_W'(4'b0111))) begin
            op_ok = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            src1_q       <= '0;
            src2_q       <= '0;
            ctrl_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            if (accept) begin
                src1_q       <= grant_d ? req1_src1_i : req0_src1_i;
                src2_q       <= grant_d ? req1_src2_i : req0_src2_i;
                ctrl_q       <= grant_d ? req1_ctrl_i : req0_ctrl_i;
                rsp_id_q     <= grant_d;
                last_grant_q <= grant_d;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    // Unsupported ops report a zero result with the error flag.
                    rsp_result_q <= op_ok ? alu_result_i : '0;
                    rsp_zero_q   <= op_ok ? alu_zero_i : 1'b1;
                    rsp_err_q    <= !op_ok;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= accept ? EXEC : IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign alu_src1_o   = src1_q;
    assign alu_src2_o   = src2_q;
    assign alu_ctrl_o   = ctrl_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = rsp_id_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_zero_o   = rsp_zero_q;
    assign rsp_err_o    = rsp_err_q;

`ifdef ALU_ARB_PERF_EN
    logic [31:0] perf_grant0_q;
    logic [31:0] perf_grant1_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            perf_grant0_q <= '0;
            perf_grant1_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (req0_valid_i && req0_ready_o) begin
                perf_grant0_q <= perf_grant0_q + 32'd1;
            end
            if (req1_valid_i && req1_ready_o) begin
                perf_grant1_q <= perf_grant1_q + 32'd1;
            end
            if (rsp_valid_q && !rsp_ready_i) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_grant0_o = perf_grant0_q;
    assign perf_grant1_o = perf_grant1_q;
    assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_BAD = 4'b0011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0v, r1v, r0rdy, r1rdy;
    logic [31:0] r0a, r0b, r1a, r1b;
    logic [3:0]  r0c, r1c;
    logic [31:0] alu_a, alu_b, alu_res;
    logic [3:0]  alu_c;
    logic        alu_z;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
    logic [31:0] rsp_result;
`ifdef ALU_ARB_PERF_EN
    logic [31:0] perf_g0, perf_g1, perf_st;
`endif

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk_i(clk), .rst_i(rst_n),
        .req0_valid_i(r0v), .req0_ready_o(r0rdy), .req0_src1_i(r0a), .req0_src2_i(r0b), .req0_ctrl_i(r0c),
        .req1_valid_i(r1v), .req1_ready_o(r1rdy), .req1_src1_i(r1a), .req1_src2_i(r1b), .req1_ctrl_i(r1c),
        .alu_src1_o(alu_a), .alu_src2_o(alu_b), .alu_ctrl_o(alu_c),
        .alu_result_i(alu_res), .alu_zero_i(alu_z),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero), .rsp_err_o(rsp_err)
`ifdef ALU_ARB_PERF_EN
        , .perf_grant0_o(perf_g0), .perf_grant1_o(perf_g1), .perf_stall_o(perf_st)
`endif
    );

    // Reference combinational ALU; unsupported codes return garbage on purpose.
    always_comb begin
        case (alu_c)
            OP_AND:  alu_res = alu_a & alu_b;
            OP_OR:   alu_res = alu_a | alu_b;
            OP_ADD:  alu_res = alu_a + alu_b;
            OP_SUB:  alu_res = alu_a - alu_b;
            OP_SLT:  alu_res = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_res = 32'hDEADBEEF;
        endcase
        alu_z = (alu_res == 32'd0);
    end

    typedef struct {
        logic        id;
        logic [31:0] res;
        logic        zero;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   acc_log[$];
    int   rsp_cyc[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Monitor: pops the scoreboard on every response handshake and checks
    // that a stalled response stays frozen with both request ports blocked.
    logic        prev_hold = 1'b0;
    logic [31:0] h_res;
    logic        h_id, h_zero, h_err;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hold = 1'b0;
            end else begin
                chk("one_ready", {31'd0, r0rdy & r1rdy}, 32'd0);
                if (rsp_valid && rsp_ready) begin
                    rsp_cyc.push_back(cyc);
                    if (sb.size() == 0) begin
                        fail_now("unexpected_rsp");
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
                        chk("rsp_result", rsp_result, e.res);
                        chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.zero});
                        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    end
                end
                if (rsp_valid && !rsp_ready) begin
                    chk("bp_readies", {30'd0, r0rdy, r1rdy}, 32'd0);
                    if (prev_hold) begin
                        chk("hold_result", rsp_result, h_res);
                        chk("hold_meta", {29'd0, rsp_id, rsp_zero, rsp_err}, {29'd0, h_id, h_zero, h_err});
                    end
                end
                prev_hold = rsp_valid && !rsp_ready;
                h_res = rsp_result; h_id = rsp_id; h_zero = rsp_zero; h_err = rsp_err;
            end
        end
    end

    task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        if (p == 0) begin r0v = 1'b1; r0a = a; r0b = b; r0c = c; end
        else        begin r1v = 1'b1; r1a = a; r1b = b; r1c = c; end
    endtask

    task automatic drop(input int p);
        if (p == 0) r0v = 1'b0; else r1v = 1'b0;
    endtask

    function automatic exp_t mk(input int p, input logic [31:0] r, input logic z, input logic er);
        exp_t e;
        e.id = (p != 0); e.res = r; e.zero = z; e.err = er;
        return e;
    endfunction

    // Holds valid until accepted; valid stays high on return.
    task automatic send(input int p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                        input logic [31:0] er, input logic ez, input logic ee);
        int n = 0;
        set_req(p, a, b, c);
        forever begin
            @(negedge clk);
            if ((p == 0) ? r0rdy : r1rdy) begin
                sb.push_back(mk(p, er, ez, ee));
                acc_log.push_back(p);
                break;
            end
            n++;
            if (n > 50) begin fail_now("accept_timeout"); break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 || rsp_valid) begin
            @(negedge clk);
            n++;
            if (n > 100) begin fail_now("drain_timeout"); sb.delete(); break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_rsp_valid();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n <= 50);
        if (!rsp_valid) fail_now("rsp_valid_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_grants[4] = '{0, 1, 0, 1};
        rst_n = 1'b0; rsp_ready = 1'b0;
        r0v = 1'b0; r0a = '0; r0b = '0; r0c = '0;
        r1v = 1'b0; r1a = '0; r1b = '0; r1c = '0;

        // Reset values.
        @(negedge clk);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_alu_src1", alu_a, 32'd0);
        chk("rst_flags", {28'd0, rsp_id, rsp_zero, rsp_err, |alu_c}, 32'd0);
        chk("rst_readies", {30'd0, r0rdy, r1rdy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single op latency: 5 + 3.
        rsp_ready = 1'b1;
        set_req(0, 32'd5, 32'd3, OP_ADD);
        @(negedge clk);
        chk("t1_ready0", {31'd0, r0rdy}, 32'd1);
        if (r0rdy) begin sb.push_back(mk(0, 32'd8, 1'b0, 1'b0)); acc_log.push_back(0); end
        @(posedge clk); #1 drop(0);
        @(negedge clk);
        chk("t1_exec_no_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t1_alu_src1", alu_a, 32'd5);
        @(negedge clk);
        chk("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        wait_drain();
        chk("t1_alu_hold", {alu_c, alu_b[27:0]}, {OP_ADD, 28'd3});

        // Port 1 alone, so last_grant is 1 going into contention.
        send(1, 32'hFF00FF00, 32'h0FF00FF0, OP_AND, 32'h0F000F00, 1'b0, 1'b0);
        drop(1);
        wait_drain();

        // Contention: grants alternate starting with port 0, one op per 2 cycles.
        acc_log.delete(); rsp_cyc.delete();
        fork
            begin
                send(0, 32'd7, 32'd7, OP_SUB, 32'd0, 1'b1, 1'b0);
                send(0, 32'd7, 32'd7, OP_SUB, 32'd0, 1'b1, 1'b0);
                drop(0);
            end
            begin
                send(1, 32'hF0, 32'h0F, OP_OR, 32'hFF, 1'b0, 1'b0);
                send(1, 32'hF0, 32'h0F, OP_OR, 32'hFF, 1'b0, 1'b0);
                drop(1);
            end
        join
        wait_drain();
        chk("t2_grant_count", acc_log.size(), 32'd4);
        for (int i = 0; i < 4 && i < acc_log.size(); i++) chk("t2_grant_order", acc_log[i], exp_grants[i]);
        chk("t2_rsp_count", rsp_cyc.size(), 32'd4);
        for (int i = 1; i < rsp_cyc.size(); i++) chk("t2_rsp_spacing", rsp_cyc[i] - rsp_cyc[i-1], 32'd2);

        // Backpressure: 0xFFFFFFFF + 1 wraps to zero; port 1 waits for rsp_ready.
        rsp_ready = 1'b0;
        send(0, 32'hFFFFFFFF, 32'd1, OP_ADD, 32'd0, 1'b1, 1'b0);
        drop(0);
        wait_rsp_valid();
        set_req(1, 32'd3, 32'd5, OP_SUB);
        repeat (5) begin
            @(negedge clk);
            chk("t3_ready1_blocked", {31'd0, r1rdy}, 32'd0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("t3_ready1_same_cycle", {31'd0, r1rdy}, 32'd1);
        if (r1rdy) sb.push_back(mk(1, 32'hFFFFFFFE, 1'b0, 1'b0));
        @(posedge clk); #1 drop(1);
        wait_drain();

        // SLT (signed) and an unsupported op.
        send(0, 32'd2, 32'd9, OP_SLT, 32'd1, 1'b0, 1'b0);
        send(0, 32'hFFFFFFFF, 32'd1, OP_SLT, 32'd1, 1'b0, 1'b0);
        send(0, 32'd2, 32'd9, OP_BAD, 32'd0, 1'b1, 1'b1);
        drop(0);
        wait_drain();
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("t4_back_to_idle", {30'd0, rsp_valid, r0rdy}, 32'd1);
        @(posedge clk); #1 rsp_ready = 1'b1;

        // Reset during EXEC after a port 0 win: port 0 must still win next.
        send(0, 32'd1, 32'd1, OP_ADD, 32'd2, 1'b0, 1'b0);
        drop(0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t5_rst_readies", {30'd0, r0rdy, r1rdy}, 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        acc_log.delete();
        fork
            begin send(0, 32'hF0, 32'h3C, OP_AND, 32'h30, 1'b0, 1'b0); drop(0); end
            begin send(1, 32'd1, 32'd1, OP_ADD, 32'd2, 1'b0, 1'b0); drop(1); end
        join
        wait_drain();
        chk("t5_first_grant", (acc_log.size() > 0) ? acc_log[0] : 99, 32'd0);

        // Reset while a response is stalled drops rsp_valid immediately.
        rsp_ready = 1'b0;
        send(1, 32'd4, 32'd4, OP_OR, 32'd4, 1'b0, 1'b0);
        drop(1);
        wait_rsp_valid();
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_resp_valid", {31'd0, rsp_valid}, 32'd0);
        sb.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        rsp_ready = 1'b1;

`ifdef ALU_ARB_PERF_EN
        send(0, 32'd1, 32'd2, OP_ADD, 32'd3, 1'b0, 1'b0); drop(0);
        send(0, 32'd1, 32'd2, OP_OR,  32'd3, 1'b0, 1'b0); drop(0);
        wait_drain();
        rsp_ready = 1'b0;
        send(0, 32'd6, 32'd6, OP_SUB, 32'd0, 1'b1, 1'b0); drop(0);
        wait_rsp_valid();
        repeat (4) @(posedge clk);
        #1 rsp_ready = 1'b1;
        send(1, 32'd1, 32'd0, OP_AND, 32'd0, 1'b1, 1'b0); drop(1);
        send(1, 32'd8, 32'd1, OP_SLT, 32'd0, 1'b1, 1'b0); drop(1);
        wait_drain();
        chk("perf_grant0", perf_g0, 32'd3);
        chk("perf_grant1", perf_g1, 32'd2);
        chk("perf_stall", perf_st, 32'd4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
